alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: registered ALU issue stage. Decodes ALUOp/funct into the
// 4-bit ALU control code, selects operands, and buffers up to DEPTH decoded
// ops behind a valid/ready handshake. Also keeps a saturating count of
// accepted illegal ops.
module alu_issue_ctrl #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [2:0]       aluop_i,
   input  logic [5:0]       funct_i,
   input  logic [4:0]       shamt_i,
   input  logic             alusrc_i,
   input  logic [31:0]      rs_data_i,
   input  logic [31:0]      rt_data_i,
   input  logic [31:0]      imm_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [3:0]       ctrl_o,
   output logic [31:0]      src1_o,
   output logic [31:0]      src2_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] illegal_cnt_o
);

   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int COUNT_W = $clog2(DEPTH + 1);

   // Returns {illegal, ctrl}; an undefined op yields 5'h1F (illegal, ctrl=F).
   function automatic logic [4:0] decode_op(input logic [2:0] aluop,
                                            input logic [5:0] funct);
      logic [4:0] r;
      r = 5'h1F;
      case (aluop)
         3'b000: r = 5'h02;
         3'b001: r = 5'h06;
         3'b010: begin
            case (funct)
               6'h20:   r = 5'h02;
               6'h22:   r = 5'h06;
               6'h24:   r = 5'h00;
               6'h25:   r = 5'h01;
               6'h2A:   r = 5'h07;
               6'h27:   r = 5'h0C;
               6'h03:   r = 5'h09;
               6'h07:   r = 5'h09;
               default: r = 5'h1F;
            endcase
         end
         3'b011: r = 5'h07;
         3'b100: r = 5'h01;
         3'b101: r = 5'h0A;
         3'b110: r = 5'h0B;
         default: r = 5'h1F;
      endcase
      return r;
   endfunction

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [3:0]         ctrl_p0;
   logic               illegal_p0;
   logic [31:0]        src1_p0;
   logic [31:0]        src2_p0;

   logic [3:0]         ctrl_mem_p1    [DEPTH];
   logic [31:0]        src1_mem_p1    [DEPTH];
   logic [31:0]        src2_mem_p1    [DEPTH];
   logic               illegal_mem_p1 [DEPTH];

   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [COUNT_W-1:0] count;
   logic [CNT_W-1:0]   illegal_cnt;
   logic               push;
   logic               pop;

   // Stage p0: combinational decode and operand select of the incoming op.
   always_comb begin
      {illegal_p0, ctrl_p0} = decode_op(aluop_i, funct_i);
      src1_p0 = ((aluop_i == 3'b010) && (funct_i == 6'h03)) ? {27'b0, shamt_i} : rs_data_i;
      src2_p0 = alusrc_i ? imm_i : rt_data_i;
   end

   assign ready_o = (count < COUNT_W'(DEPTH));
   assign valid_o = (count != '0);
   assign push    = valid_i & ready_o;
   assign pop     = valid_o & ready_i;

   // Stage p1: entry storage; payload needs no reset since outputs are masked when empty.
   always_ff @(posedge clk_i) begin
      if (push && !flush_i) begin
         ctrl_mem_p1[wr_ptr]    <= ctrl_p0;
         src1_mem_p1[wr_ptr]    <= src1_p0;
         src2_mem_p1[wr_ptr]    <= src2_p0;
         illegal_mem_p1[wr_ptr] <= illegal_p0;
      end
   end

   // Queue control: pointers and occupancy; flush beats any push/pop.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + COUNT_W'(1);
            2'b01:   count <= count - COUNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Illegal-op counter: counts accepted illegal pushes, survives flush.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         illegal_cnt <= '0;
      end else if (push && !flush_i && illegal_p0) begin
         illegal_cnt <= sat_inc(illegal_cnt);
      end
   end

   // Head presentation: zero when the queue is empty.
   always_comb begin
      ctrl_o    = '0;
      src1_o    = '0;
      src2_o    = '0;
      illegal_o = 1'b0;
      if (valid_o) begin
         ctrl_o    = ctrl_mem_p1[rd_ptr];
         src1_o    = src1_mem_p1[rd_ptr];
         src2_o    = src2_mem_p1[rd_ptr];
         illegal_o = illegal_mem_p1[rd_ptr];
      end
   end

   assign illegal_cnt_o = illegal_cnt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl: inputs driven and outputs checked
// on the falling clock edge.
module tb_alu_issue_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        flush_i;
   logic        valid_i;
   logic        ready_o;
   logic [2:0]  aluop_i;
   logic [5:0]  funct_i;
   logic [4:0]  shamt_i;
   logic        alusrc_i;
   logic [31:0] rs_data_i;
   logic [31:0] rt_data_i;
   logic [31:0] imm_i;
   logic        valid_o;
   logic        ready_i;
   logic [3:0]  ctrl_o;
   logic [31:0] src1_o;
   logic [31:0] src2_o;
   logic        illegal_o;
   logic [7:0]  illegal_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;

   alu_issue_ctrl #(.DEPTH(2), .CNT_W(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .valid_i(valid_i), .ready_o(ready_o),
      .aluop_i(aluop_i), .funct_i(funct_i), .shamt_i(shamt_i),
      .alusrc_i(alusrc_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
      .imm_i(imm_i), .valid_o(valid_o), .ready_i(ready_i),
      .ctrl_o(ctrl_o), .src1_o(src1_o), .src2_o(src2_o),
      .illegal_o(illegal_o), .illegal_cnt_o(illegal_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic set_idle();
      flush_i = 0; valid_i = 0; ready_i = 0;
      aluop_i = 0; funct_i = 0; shamt_i = 0; alusrc_i = 0;
      rs_data_i = 0; rt_data_i = 0; imm_i = 0;
   endtask

   task automatic drive_op(input logic [2:0] aluop, input logic [5:0] funct,
                           input logic [4:0] shamt, input logic alusrc,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] imm);
      valid_i = 1; aluop_i = aluop; funct_i = funct; shamt_i = shamt;
      alusrc_i = alusrc; rs_data_i = rs; rt_data_i = rt; imm_i = imm;
   endtask

   task automatic test_reset();
      set_idle();
      rst_i = 0;
      valid_i = 1;
      repeat (2) @(negedge clk_i);
      valid_i = 0;
      rst_i = 1;
      @(negedge clk_i);
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", valid_o); end
      n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0h want 1", ready_o); end
      n_checks++; if (ctrl_o !== 4'h0) begin n_fail++; $display("FAIL reset_ctrl: got %0h want 0", ctrl_o); end
      n_checks++; if (src1_o !== 32'h0 || src2_o !== 32'h0 || illegal_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_data: got %0h %0h %0h want 0 0 0", src1_o, src2_o, illegal_o); end
      n_checks++; if (illegal_cnt_o !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", illegal_cnt_o); end
   endtask

   task automatic test_rtype_sra();
      ready_i = 1;
      drive_op(3'b010, 6'h03, 5'd4, 1'b0, 32'hDEADBEEF, 32'hF0000000, 32'h0);
      @(negedge clk_i);
      valid_i = 0;
      n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL sra_valid: got %0h want 1", valid_o); end
      n_checks++; if (ctrl_o !== 4'd9) begin n_fail++; $display("FAIL sra_ctrl: got %0d want 9", ctrl_o); end
      n_checks++; if (src1_o !== 32'h4) begin n_fail++; $display("FAIL sra_src1: got %0h want 4", src1_o); end
      n_checks++; if (src2_o !== 32'hF0000000) begin n_fail++; $display("FAIL sra_src2: got %0h want f0000000", src2_o); end
      @(negedge clk_i);
      n_checks++; if (valid_o !== 1'b0 || ctrl_o !== 4'h0) begin
         n_fail++; $display("FAIL sra_drain: got valid %0h ctrl %0h want 0 0", valid_o, ctrl_o); end
   endtask

   task automatic test_full_backpressure();
      ready_i = 0;
      drive_op(3'b000, 6'h00, 5'd0, 1'b1, 32'd5, 32'h99, 32'hFFFFFFFF);
      @(negedge clk_i);
      n_checks++; if (ready_o !== 1'b1 || valid_o !== 1'b1) begin
         n_fail++; $display("FAIL full_one: got ready %0h valid %0h want 1 1", ready_o, valid_o); end
      drive_op(3'b101, 6'h00, 5'd0, 1'b1, 32'h77, 32'h88, 32'h1234);
      @(negedge clk_i);
      n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0h want 0", ready_o); end
      drive_op(3'b001, 6'h00, 5'd0, 1'b0, 32'h1, 32'h2, 32'h3);
      @(negedge clk_i);
      valid_i = 0;
      n_checks++; if (ready_o !== 1'b0 || ctrl_o !== 4'd2) begin
         n_fail++; $display("FAIL full_hold: got ready %0h ctrl %0d want 0 2", ready_o, ctrl_o); end
      ready_i = 1;
      n_checks++; if (ctrl_o !== 4'd2 || src1_o !== 32'd5 || src2_o !== 32'hFFFFFFFF) begin
         n_fail++; $display("FAIL full_head0: got %0d %0h %0h want 2 5 ffffffff", ctrl_o, src1_o, src2_o); end
      @(negedge clk_i);
      n_checks++; if (ctrl_o !== 4'd10 || src1_o !== 32'h77 || src2_o !== 32'h1234 || ready_o !== 1'b1) begin
         n_fail++; $display("FAIL full_head1: got %0d %0h %0h rdy %0h want 10 77 1234 1", ctrl_o, src1_o, src2_o, ready_o); end
      @(negedge clk_i);
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL full_third_dropped: got valid %0h want 0", valid_o); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] ops   [8] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b010, 3'b010};
      logic [5:0] fns   [8] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h25, 6'h27};
      logic [3:0] exp_c [8] = '{4'd2, 4'd6, 4'd7, 4'd1, 4'd10, 4'd11, 4'd1, 4'd12};
      ready_i = 1;
      for (int i = 0; i < 8; i++) begin
         drive_op(ops[i], fns[i], 5'd0, 1'b0, 32'h100 + i, 32'h200 + i, 32'h0);
         @(negedge clk_i);
         n_checks++;
         if (valid_o !== 1'b1 || ready_o !== 1'b1 || ctrl_o !== exp_c[i] ||
             src1_o !== 32'h100 + i || src2_o !== 32'h200 + i) begin
            n_fail++;
            $display("FAIL b2b_%0d: got v%0h r%0h %0d %0h %0h want v1 r1 %0d %0h %0h",
                     i, valid_o, ready_o, ctrl_o, src1_o, src2_o, exp_c[i], 32'h100 + i, 32'h200 + i);
         end
      end
      valid_i = 0;
      @(negedge clk_i);
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %0h want 0", valid_o); end
   endtask

   task automatic test_illegal();
      ready_i = 0;
      drive_op(3'b010, 6'h3F, 5'd7, 1'b0, 32'hAAAA, 32'hBBBB, 32'h0);
      @(negedge clk_i);
      n_checks++; if (ctrl_o !== 4'hF || illegal_o !== 1'b1 || src1_o !== 32'hAAAA || illegal_cnt_o !== 8'd1) begin
         n_fail++; $display("FAIL ill_funct: got %0h %0h %0h %0d want f 1 aaaa 1", ctrl_o, illegal_o, src1_o, illegal_cnt_o); end
      drive_op(3'b111, 6'h20, 5'd0, 1'b1, 32'hCCCC, 32'hDDDD, 32'h55);
      @(negedge clk_i);
      valid_i = 0;
      ready_i = 1;
      n_checks++; if (illegal_cnt_o !== 8'd2) begin n_fail++; $display("FAIL ill_cnt2: got %0d want 2", illegal_cnt_o); end
      @(negedge clk_i);
      n_checks++; if (ctrl_o !== 4'hF || illegal_o !== 1'b1 || src1_o !== 32'hCCCC || src2_o !== 32'h55) begin
         n_fail++; $display("FAIL ill_aluop: got %0h %0h %0h %0h want f 1 cccc 55", ctrl_o, illegal_o, src1_o, src2_o); end
      @(negedge clk_i);
   endtask

   task automatic test_flush();
      ready_i = 0;
      drive_op(3'b000, 6'h00, 5'd0, 1'b0, 32'h11, 32'h22, 32'h0);
      @(negedge clk_i);
      drive_op(3'b001, 6'h00, 5'd0, 1'b0, 32'h33, 32'h44, 32'h0);
      @(negedge clk_i);
      n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_full: got ready %0h want 0", ready_o); end
      drive_op(3'b111, 6'h00, 5'd0, 1'b0, 32'h55, 32'h66, 32'h0);
      flush_i = 1;
      ready_i = 1;
      @(negedge clk_i);
      flush_i = 0;
      valid_i = 0;
      n_checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || illegal_cnt_o !== 8'd2) begin
         n_fail++; $display("FAIL flush_clear: got v%0h r%0h cnt %0d want v0 r1 cnt 2", valid_o, ready_o, illegal_cnt_o); end
      drive_op(3'b100, 6'h00, 5'd0, 1'b1, 32'h123, 32'h0, 32'h456);
      @(negedge clk_i);
      valid_i = 0;
      n_checks++; if (ctrl_o !== 4'd1 || src1_o !== 32'h123 || src2_o !== 32'h456) begin
         n_fail++; $display("FAIL flush_after: got %0d %0h %0h want 1 123 456", ctrl_o, src1_o, src2_o); end
      @(negedge clk_i);
   endtask

   task automatic test_saturate();
      ready_i = 1;
      for (int i = 0; i < 300; i++) begin
         drive_op(3'b111, 6'h00, 5'd0, 1'b0, i, 32'h0, 32'h0);
         @(negedge clk_i);
         if (i == 99) begin
            n_checks++; if (illegal_cnt_o !== 8'd102) begin n_fail++; $display("FAIL sat_mid: got %0d want 102", illegal_cnt_o); end
         end
      end
      valid_i = 0;
      @(negedge clk_i);
      n_checks++; if (illegal_cnt_o !== 8'd255) begin n_fail++; $display("FAIL sat_cnt: got %0d want 255", illegal_cnt_o); end
      n_checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
         n_fail++; $display("FAIL sat_drain: got v%0h r%0h want v0 r1", valid_o, ready_o); end
   endtask

   task automatic test_reset_mid();
      ready_i = 0;
      drive_op(3'b000, 6'h00, 5'd0, 1'b0, 32'h9, 32'h9, 32'h0);
      @(negedge clk_i);
      valid_i = 0;
      n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got %0h want 1", valid_o); end
      rst_i = 0;
      @(negedge clk_i);
      rst_i = 1;
      n_checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || ctrl_o !== 4'h0 || illegal_cnt_o !== 8'd0) begin
         n_fail++; $display("FAIL rstmid_clear: got v%0h r%0h c%0h cnt %0d want v0 r1 c0 cnt 0", valid_o, ready_o, ctrl_o, illegal_cnt_o); end
      @(negedge clk_i);
      n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: got %0h want 0", valid_o); end
   endtask

   initial begin
      set_idle();
      rst_i = 0;
      test_reset();
      test_rtype_sra();
      test_full_backpressure();
      test_back_to_back();
      test_illegal();
      test_flush();
      test_saturate();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
